// File: rtl/row_readout_pkg.sv
// Shared state encoding and default widths for the row token readout controller.
package row_readout_pkg;

    localparam int unsigned ROW_NROWS = 16;
    localparam int unsigned ROW_AW    = 4;
    localparam int unsigned ROW_DW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_READ = 3'd2,
        ST_CAPT = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/row_priority_enc.sv
// Combinational lowest-index-first priority encoder over the row token vector.
module row_priority_enc #(
    parameter int unsigned NROWS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic [NROWS-1:0] token,
    output logic [AW-1:0]    Addr,
    output logic [NROWS-1:0] OneHot,
    output logic             Any
);

    always_comb begin
        Addr = '0;
        Any  = 1'b0;
        for (int unsigned i = 0; i < NROWS; i++) begin
            if (token[i] && !Any) begin
                Addr = AW'(i);
                Any  = 1'b1;
            end
        end
    end

    // Isolate the lowest set bit.
    assign OneHot = token & (~token + NROWS'(1));

endmodule

// File: rtl/row_token_readout_ctrl.sv
// Column row readout sequencer: snapshots pending rows, strobes each row, forwards data on valid/ready.
// Optional row masking is enabled with `define ROW_READOUT_MASK_EN.
module row_token_readout_ctrl
    import row_readout_pkg::*;
#(
    parameter int unsigned NROWS = ROW_NROWS,
    parameter int unsigned AW    = ROW_AW,
    parameter int unsigned DW    = ROW_DW
) (
    input  logic             Clk,
    input  logic             ResetB,
    input  logic             Start,
    input  logic             Abort,
    input  logic [NROWS-1:0] HitPending,
`ifdef ROW_READOUT_MASK_EN
    input  logic [NROWS-1:0] RowMask,
`endif
    output logic [NROWS-1:0] RowRead,
    input  logic [DW-1:0]    RowData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [AW-1:0]    OutAddr,
    output logic [DW-1:0]    OutData,
    output logic             Busy,
    output logic             Done,
    output logic [AW:0]      ReadCount
);

    localparam int unsigned CW = AW + 1;

    state_e           state_q, state_d;
    logic [NROWS-1:0] token_q, token_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NROWS-1:0] row_read_q, row_read_d;
    logic             out_valid_q, out_valid_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    read_count_q, read_count_d;

    logic [NROWS-1:0] snap_c;
    logic [AW-1:0]    enc_addr;
    logic [NROWS-1:0] enc_onehot;
    logic             enc_any;

`ifdef ROW_READOUT_MASK_EN
    assign snap_c = HitPending & ~RowMask;
`else
    assign snap_c = HitPending;
`endif

    row_priority_enc #(
        .NROWS (NROWS),
        .AW    (AW)
    ) u_enc (
        .token  (token_q),
        .Addr   (enc_addr),
        .OneHot (enc_onehot),
        .Any    (enc_any)
    );

    always_comb begin
        state_d      = state_q;
        token_d      = token_q;
        addr_d       = addr_q;
        row_read_d   = '0;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        read_count_d = read_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    token_d      = snap_c;
                    read_count_d = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enc_any) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d     = enc_addr;
                    row_read_d = enc_onehot;
                    state_d    = ST_READ;
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                out_data_d  = RowData;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (OutReady) begin
                    token_d      = token_q & ~(NROWS'(1) << addr_q);
                    read_count_d = read_count_q + CW'(1);
                    out_valid_d  = 1'b0;
                    state_d      = ST_SCAN;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything except the delivered-row count.
        if (Abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            token_d      = '0;
            row_read_d   = '0;
            out_valid_d  = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            read_count_d = read_count_q;
        end
    end

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            state_q      <= ST_IDLE;
            token_q      <= '0;
            addr_q       <= '0;
            row_read_q   <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            read_count_q <= '0;
        end else begin
            state_q      <= state_d;
            token_q      <= token_d;
            addr_q       <= addr_d;
            row_read_q   <= row_read_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            read_count_q <= read_count_d;
        end
    end

    assign RowRead   = row_read_q;
    assign OutValid  = out_valid_q;
    assign OutAddr   = out_addr_q;
    assign OutData   = out_data_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ReadCount = read_count_q;

endmodule

// File: tb/tb_row_token_readout_ctrl.sv
// Scoreboard bench for row_token_readout_ctrl; masking scenario runs when ROW_READOUT_MASK_EN is defined.
module tb_row_token_readout_ctrl;

    logic        Clk;
    logic        ResetB;
    logic        Start;
    logic        Abort;
    logic [15:0] HitPending;
    logic [15:0] RowMask;
    logic [15:0] RowRead;
    logic [15:0] RowData;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  OutAddr;
    logic [15:0] OutData;
    logic        Busy;
    logic        Done;
    logic [4:0]  ReadCount;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rr_cnt   = 0;
    int done_cnt = 0;
    int hs_cyc_last = 0;
    int hs_cyc_prev = 0;
    logic [19:0] sb[$];
    logic [15:0] rr;

    row_token_readout_ctrl dut (
        .Clk        (Clk),
        .ResetB     (ResetB),
        .Start      (Start),
        .Abort      (Abort),
        .HitPending (HitPending),
`ifdef ROW_READOUT_MASK_EN
        .RowMask    (RowMask),
`endif
        .RowRead    (RowRead),
        .RowData    (RowData),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutAddr    (OutAddr),
        .OutData    (OutData),
        .Busy       (Busy),
        .Done       (Done),
        .ReadCount  (ReadCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] row_pat(input int r);
        return 16'hC300 ^ 16'(r * 16'h0111);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] snap);
        for (int i = 0; i < 16; i++)
            if (snap[i]) sb.push_back({4'(i), row_pat(i)});
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!OutValid && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!OutValid) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!Done && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!Done) check("done_timeout", 0, 1);
    endtask

    // Pixel-row model: a strobe seen in one cycle puts that row's word on the bus for the next cycle.
    always begin
        @(negedge Clk);
        rr = RowRead;
        @(posedge Clk); #1;
        RowData = (rr != 16'h0) ? row_pat($clog2(rr)) : 16'hDEAD;
    end

    always @(negedge Clk) begin
        if (ResetB) begin
            if (RowRead != 16'h0) begin
                rr_cnt++;
                check("rowread_onehot", 32'($countones(RowRead)), 1);
            end
            if (Done) done_cnt++;
            if (OutValid && OutReady) begin
                hs_cyc_prev = hs_cyc_last;
                hs_cyc_last = cyc;
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    logic [19:0] e;
                    e = sb.pop_front();
                    check("out_addr", 32'(OutAddr), 32'(e[19:16]));
                    check("out_data", 32'(OutData), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        int n;
        int rr0;
        int d0;
        ResetB     = 1'b0;
        Start      = 1'b0;
        Abort      = 1'b0;
        HitPending = 16'h0;
        RowMask    = 16'h0;
        RowData    = 16'hDEAD;
        OutReady   = 1'b1;
        #12;
        check("rst_busy", 32'(Busy), 0);
        check("rst_valid", 32'(OutValid), 0);
        check("rst_rowread", 32'(RowRead), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_count", 32'(ReadCount), 0);
        check("rst_addr", 32'(OutAddr), 0);
        check("rst_data", 32'(OutData), 0);
        #11 ResetB = 1'b1;
        @(posedge Clk); #1;

        // Rows 0 and 15, back to back.
        HitPending = 16'h8001;
        push_exp(HitPending);
        rr0 = rr_cnt; d0 = done_cnt;
        pulse_start();
        check("busy_after_start", 32'(Busy), 1);
        wait_valid(20, n);
        check("first_valid_latency", 32'(n + 1), 4);
        wait_done(60, n);
        check("t1_count", 32'(ReadCount), 2);
        check("t1_rowreads", 32'(rr_cnt - rr0), 2);
        check("t1_row_gap", 32'(hs_cyc_last - hs_cyc_prev), 4);
        check("t1_sb_empty", 32'(sb.size()), 0);
        @(posedge Clk); #1;
        check("t1_done_count", 32'(done_cnt - d0), 1);
        check("t1_idle", 32'(Busy), 0);

        // Empty snapshot.
        HitPending = 16'h0;
        rr0 = rr_cnt;
        pulse_start();
        wait_done(20, n);
        check("empty_done_latency", 32'(n + 1), 2);
        check("t2_count", 32'(ReadCount), 0);
        check("t2_rowreads", 32'(rr_cnt - rr0), 0);
        @(posedge Clk); #1;

        // Backpressure holds the output word.
        HitPending = 16'h0006;
        OutReady   = 1'b0;
        push_exp(HitPending);
        pulse_start();
        wait_valid(20, n);
        repeat (10) begin
            @(posedge Clk); #1;
            check("hold_valid", 32'(OutValid), 1);
            check("hold_addr", 32'(OutAddr), 1);
            check("hold_data", 32'(OutData), 32'(row_pat(1)));
        end
        OutReady = 1'b1;
        wait_done(60, n);
        check("t3_count", 32'(ReadCount), 2);
        check("t3_sb_empty", 32'(sb.size()), 0);
        @(posedge Clk); #1;

        // Full column; snapshot change and second Start while busy are ignored.
        HitPending = 16'hFFFF;
        push_exp(HitPending);
        rr0 = rr_cnt; d0 = done_cnt;
        pulse_start();
        repeat (6) @(posedge Clk);
        #1;
        HitPending = 16'h0001;
        pulse_start();
        wait_done(200, n);
        check("t4_count", 32'(ReadCount), 16);
        check("t4_rowreads", 32'(rr_cnt - rr0), 16);
        check("t4_sb_empty", 32'(sb.size()), 0);
        repeat (5) @(posedge Clk);
        #1;
        check("t4_done_count", 32'(done_cnt - d0), 1);
        check("t4_idle", 32'(Busy), 0);

        // Abort while row 5 waits in OUT.
        HitPending = 16'h00F0;
        OutReady   = 1'b0;
        sb.push_back({4'd4, row_pat(4)});
        d0 = done_cnt;
        pulse_start();
        wait_valid(20, n);
        check("t5_first_addr", 32'(OutAddr), 4);
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
        wait_valid(20, n);
        check("t5_second_addr", 32'(OutAddr), 5);
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        check("abort_busy", 32'(Busy), 0);
        check("abort_valid", 32'(OutValid), 0);
        check("abort_rowread", 32'(RowRead), 0);
        check("abort_count", 32'(ReadCount), 1);
        repeat (4) @(posedge Clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_stays_idle", 32'(Busy), 0);
        OutReady   = 1'b1;
        HitPending = 16'h0008;
        push_exp(HitPending);
        pulse_start();
        wait_done(40, n);
        check("restart_count", 32'(ReadCount), 1);
        check("t5_sb_empty", 32'(sb.size()), 0);
        @(posedge Clk); #1;

`ifdef ROW_READOUT_MASK_EN
        HitPending = 16'h000F;
        RowMask    = 16'h0005;
        push_exp(HitPending & ~RowMask);
        rr0 = rr_cnt;
        pulse_start();
        wait_done(60, n);
        check("mask_count", 32'(ReadCount), 2);
        check("mask_rowreads", 32'(rr_cnt - rr0), 2);
        check("mask_sb_empty", 32'(sb.size()), 0);
        RowMask = 16'h0;
        @(posedge Clk); #1;
`endif

        // Asynchronous reset in the middle of a pass.
        HitPending = 16'hFFFF;
        push_exp(HitPending);
        pulse_start();
        repeat (10) @(posedge Clk);
        #3;
        ResetB = 1'b0;
        #1;
        check("async_rst_busy", 32'(Busy), 0);
        check("async_rst_count", 32'(ReadCount), 0);
        check("async_rst_valid", 32'(OutValid), 0);
        check("async_rst_addr", 32'(OutAddr), 0);
        sb.delete();
        @(posedge Clk); #2;
        ResetB = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("post_rst_idle", 32'(Busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
